// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the riscv_core divider.
package riscv_core_pkg;

    localparam int unsigned DIV_XLEN  = 64;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_XLEN) + 1;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StDone = 2'b10
    } div_state_e;

endpackage

// File: rtl/riscv_core_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module riscv_core_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            qbit_o
);

    logic [XLEN:0] shifted;

    // A set top bit means the shifted value already exceeds any XLEN-bit divisor.
    always_comb begin
        shifted = {rem_i[XLEN-1:0], msb_i};
        qbit_o  = rem_i[XLEN] | (shifted >= {1'b0, divisor_i});
        rem_o   = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;
    end

endmodule

// File: rtl/riscv_core_divider.sv
// Iterative radix-2 RV64M divider (DIV/DIVU/REM/REMU and W forms) with start/valid handshake.
// Define RISCV_CORE_DIV_EARLY_OUT_EN to finish special and trivial cases in one cycle.
module riscv_core_divider
    import riscv_core_pkg::*;
#(
    parameter int unsigned XLEN = DIV_XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_div_start,
    input  logic [1:0]      i_div_op,
    input  logic            i_div_word,
    input  logic [XLEN-1:0] i_div_rs1,
    input  logic [XLEN-1:0] i_div_rs2,
    input  logic            i_div_flush,
    output logic            o_div_ready,
    output logic            o_div_busy,
    output logic            o_div_valid,
    output logic [XLEN-1:0] o_div_result
);

    localparam int unsigned H    = XLEN / 2;
    localparam int unsigned CntW = $clog2(XLEN) + 1;

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w);
        wext = w ? {{H{v[H-1]}}, v[H-1:0]} : v;
    endfunction

    div_state_e      state_q, state_d;
    div_op_e         op_in;
    logic [CntW-1:0] cnt_q;
    logic [XLEN-1:0] dvd_q, dvs_q, result_q;
    logic [XLEN:0]   rem_q, rem_next;
    logic            neg_q_q, neg_r_q, rem_op_q, word_q, div0_q;
    logic            qbit, load, fin_load;
    logic            signed_op, rem_op, sign1, sign2, div0_in;
    logic [XLEN-1:0] rs1_ext, rs2_ext, dvd_abs, dvs_abs, dvd_init;
    logic [XLEN-1:0] q_fin, r_fin, q_res, r_res, fin_result;

    assign op_in     = div_op_e'(i_div_op);
    assign signed_op = (op_in == OpDiv) || (op_in == OpRem);
    assign rem_op    = (op_in == OpRem) || (op_in == OpRemu);

    // Operand preparation: word extension, then magnitudes of signed operands.
    always_comb begin
        rs1_ext = i_div_rs1;
        rs2_ext = i_div_rs2;
        if (i_div_word) begin
            rs1_ext = signed_op ? {{H{i_div_rs1[H-1]}}, i_div_rs1[H-1:0]}
                                : {{H{1'b0}}, i_div_rs1[H-1:0]};
            rs2_ext = signed_op ? {{H{i_div_rs2[H-1]}}, i_div_rs2[H-1:0]}
                                : {{H{1'b0}}, i_div_rs2[H-1:0]};
        end
        sign1    = signed_op & rs1_ext[XLEN-1];
        sign2    = signed_op & rs2_ext[XLEN-1];
        dvd_abs  = sign1 ? -rs1_ext : rs1_ext;
        dvs_abs  = sign2 ? -rs2_ext : rs2_ext;
        div0_in  = (rs2_ext == '0);
        // Word dividends sit in the upper half so the MSB is always at XLEN-1.
        dvd_init = i_div_word ? {dvd_abs[H-1:0], {H{1'b0}}} : dvd_abs;
    end

`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
    logic            ovf_in, small_in, early_hit;
    logic [XLEN-1:0] min_neg, early_sel, early_result;

    always_comb begin
        min_neg   = i_div_word ? {{(H + 1){1'b1}}, {(H - 1){1'b0}}}
                               : {1'b1, {(XLEN - 1){1'b0}}};
        ovf_in    = signed_op && (rs1_ext == min_neg) && (&rs2_ext);
        small_in  = dvd_abs < dvs_abs;
        early_hit = div0_in | ovf_in | small_in;
        if (div0_in) begin
            early_sel = rem_op ? rs1_ext : '1;
        end else if (ovf_in) begin
            early_sel = rem_op ? '0 : rs1_ext;
        end else begin
            early_sel = rem_op ? rs1_ext : '0;
        end
        early_result = wext(early_sel, i_div_word);
    end
`endif

    riscv_core_div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_i    (rem_q),
        .msb_i    (dvd_q[XLEN-1]),
        .divisor_i(dvs_q),
        .rem_o    (rem_next),
        .qbit_o   (qbit)
    );

    // Final values use the last iteration's step output so the result registers at DONE entry.
    // Signed overflow falls out of the magnitude arithmetic; only divide-by-zero needs a patch.
    always_comb begin
        q_fin      = {dvd_q[XLEN-2:0], qbit};
        r_fin      = rem_next[XLEN-1:0];
        q_res      = div0_q ? '1 : (neg_q_q ? -q_fin : q_fin);
        r_res      = neg_r_q ? -r_fin : r_fin;
        fin_result = wext(rem_op_q ? r_res : q_res, word_q);
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        fin_load    = 1'b0;
        o_div_ready = 1'b0;
        o_div_busy  = 1'b0;
        o_div_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                o_div_ready = 1'b1;
                if (i_div_start && !i_div_flush) begin
                    load = 1'b1;
`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
                    state_d = early_hit ? StDone : StCalc;
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                o_div_busy = 1'b1;
                if (i_div_flush) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(1)) begin
                    state_d  = StDone;
                    fin_load = 1'b1;
                end
            end
            StDone: begin
                o_div_busy  = 1'b1;
                o_div_valid = !i_div_flush;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            rem_op_q <= 1'b0;
            word_q   <= 1'b0;
            div0_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dvd_q    <= dvd_init;
                dvs_q    <= dvs_abs;
                rem_q    <= '0;
                cnt_q    <= i_div_word ? CntW'(H) : CntW'(XLEN);
                neg_q_q  <= sign1 ^ sign2;
                neg_r_q  <= sign1;
                rem_op_q <= rem_op;
                word_q   <= i_div_word;
                div0_q   <= div0_in;
            end else if (state_q == StCalc) begin
                dvd_q <= {dvd_q[XLEN-2:0], qbit};
                rem_q <= rem_next;
                cnt_q <= cnt_q - CntW'(1);
            end
            if (fin_load) begin
                result_q <= fin_result;
            end
`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
            if (load && early_hit) begin
                result_q <= early_result;
            end
`endif
        end
    end

    assign o_div_result = result_q;

endmodule

// File: tb/tb_riscv_core_divider.sv
// Directed self-checking bench for riscv_core_divider (64-bit).
module tb_riscv_core_divider;
    import riscv_core_pkg::*;

    logic        clk, rst;
    logic        start, word, flush;
    logic [1:0]  op;
    logic [63:0] rs1, rs2;
    logic        ready, busy, valid;
    logic [63:0] result;

    int total = 0;
    int bad   = 0;

`ifdef RISCV_CORE_DIV_EARLY_OUT_EN
    localparam int LatSpecial = 1;
`else
    localparam int LatSpecial = 65;
`endif
    localparam int LatSpecialW = (LatSpecial == 1) ? 1 : 33;

    riscv_core_divider #(
        .XLEN(64)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_div_start (start),
        .i_div_op    (op),
        .i_div_word  (word),
        .i_div_rs1   (rs1),
        .i_div_rs2   (rs2),
        .i_div_flush (flush),
        .o_div_ready (ready),
        .o_div_busy  (busy),
        .o_div_valid (valid),
        .o_div_result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request; acceptance edge ends cycle 0, sampling is #1 after each edge.
    task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b);
        @(negedge clk);
        start = 1'b1; op = o; word = w; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int cyc0, input logic [63:0] exp,
                              input int exp_lat);
        int  cyc;
        bit  seen;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, " valid"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " ready after"}, 64'(ready), 64'd1);
        check({tag, " valid pulse"}, 64'(valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat);
        issue(o, w, a, b);
        wait_valid(tag, 1, exp, exp_lat);
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; word = 1'b0; op = 2'b00;
        rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("div -7/2", OpDiv, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65);
        run_op("rem -7/2", OpRem, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 65);
        run_op("divu x/0", OpDivu, 1'b0, 64'h1234, 64'd0, 64'hFFFFFFFFFFFFFFFF, LatSpecial);
        run_op("remu x/0", OpRemu, 1'b0, 64'h1234, 64'd0, 64'h1234, LatSpecial);
        run_op("div ovf", OpDiv, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
               64'h8000000000000000, LatSpecial);
        run_op("rem ovf", OpRem, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
               64'd0, LatSpecial);
        run_op("divw ovf", OpDiv, 1'b1, 64'h0000000180000000, 64'h00000000FFFFFFFF,
               64'hFFFFFFFF80000000, LatSpecialW);
        run_op("divuw", OpDivu, 1'b1, 64'hFFFFFFFE, 64'd1, 64'hFFFFFFFFFFFFFFFE, 33);
        run_op("remw -7/2", OpRem, 1'b1, 64'h00000000FFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33);
        run_op("remu small", OpRemu, 1'b0, 64'd5, 64'd9, 64'd5, LatSpecial);
        run_op("div 100/-7", OpDiv, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9,
               64'hFFFFFFFFFFFFFFF2, 65);
        run_op("rem 100/-7", OpRem, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 65);

        // Flush in CALC at cycle 20: no valid, result keeps the previous value (2).
        issue(OpDivu, 1'b0, 64'd100, 64'd7);
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (valid) seen = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush ready", 64'(ready), 64'd1);
        check("flush busy", 64'(busy), 64'd0);
        check("flush early valid", 64'(seen), 64'd0);
        watch_no_valid("flush no valid", 70);
        check("flush result kept", result, 64'd2);

        // Flush and start together in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = OpDivu; rs1 = 64'd100; rs2 = 64'd7;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start ready", 64'(ready), 64'd1);
        check("flush+start busy", 64'(busy), 64'd0);
        watch_no_valid("flush+start no valid", 70);

        run_op("remu after flush", OpRemu, 1'b0, 64'd100, 64'd7, 64'd2, 65);

        // Start during CALC is ignored: original 100/7 completes, no second result.
        issue(OpDivu, 1'b0, 64'd100, 64'd7);
        cyc = 1;
        while (cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b1; op = OpDiv; rs1 = 64'hFFFFFFFFFFFFFFF9; rs2 = 64'd2;
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        wait_valid("divu calc-start", cyc, 64'd14, 65);
        watch_no_valid("calc-start no 2nd valid", 70);

        // Reset mid-operation at cycle 10.
        issue(OpDiv, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2);
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset ready", 64'(ready), 64'd1);
        check("midreset busy", 64'(busy), 64'd0);
        check("midreset valid", 64'(valid), 64'd0);
        check("midreset result", result, 64'd0);
        watch_no_valid("midreset no valid", 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_core_divider.md
Name: riscv_core_divider

Overview:
- Iterative radix-2 restoring divider implementing RV64M DIV/DIVU/REM/REMU and the W variants DIVW/DIVUW/REMW/REMUW.
- Sits in the EX stage beside the ALU. Its registered result is one input of the EX result-select 3:1 mux.
- Multi-cycle, with a start/valid handshake. The hazard unit stalls the pipeline while o_div_busy is high.

Parameters:
- XLEN, 64, datapath width; must be even. W ops use the low XLEN/2 bits.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  reset; synchronous, active-high
- i_div_start  input  1  request; accepted only when o_div_ready=1
- i_div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- i_div_word  input  1  1 = W variant (32-bit operation, sign-extended result)
- i_div_rs1  input  XLEN  dividend
- i_div_rs2  input  XLEN  divisor
- i_div_flush  input  1  abort any operation in progress
- o_div_ready  output  1  idle, can accept a request
- o_div_busy  output  1  operation in flight (CALC or DONE state)
- o_div_valid  output  1  one-cycle pulse; o_div_result is valid
- o_div_result  output  XLEN  quotient or remainder

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state <= IDLE; o_div_ready=1, o_div_busy=0, o_div_valid=0, o_div_result=0.
  - Reset overrides everything, including mid-operation.
- State machine:
  - IDLE -> CALC on i_div_start & ~i_div_flush. Operands, op and word are latched in that same cycle (call it cycle 0).
  - CALC: one quotient bit per cycle; iteration counter N = XLEN (or XLEN/2 if word). After N cycles -> DONE.
  - DONE: o_div_valid=1 for exactly one cycle -> IDLE.
  - Nominal latency: o_div_valid high in cycle N+1 after acceptance; o_div_ready high again in cycle N+2.
- Operand preparation at acceptance:
  - Word ops: take the low XLEN/2 bits, sign-extended (signed ops) or zero-extended (unsigned ops).
  - Signed ops: divide the absolute values; latch the quotient sign (sign(rs1) XOR sign(rs2)) and the remainder sign (sign(rs1)).
- Iteration: rem = {rem, dividend MSB}; if rem >= divisor then subtract and shift in quotient bit 1, else shift in 0. The remainder register is N+1 bits wide.
- Result at DONE entry (registered):
  - Negate the quotient/remainder per the latched signs.
  - Select the quotient for DIV/DIVU, the remainder for REM/REMU.
  - Word ops: sign-extend bit XLEN/2-1 of the selected result to XLEN (applies to DIVUW/REMUW as well, per ISA).
- Special cases (ISA-mandated, no trap):
  - Divisor 0: quotient = all ones (-1); remainder = dividend (post word-extension).
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- o_div_result holds its last value until the next DONE.
- Handshake rules:
  - i_div_start is ignored while o_div_ready=0; no queueing.
  - A start during DONE is not accepted. Back-to-back ops have a one-cycle IDLE gap.
- Flush:
  - i_div_flush in CALC or DONE -> IDLE next cycle; o_div_valid is suppressed (forced 0 in that DONE cycle); o_div_result unchanged.
  - Flush and start in the same IDLE cycle: flush wins, nothing is accepted.

Optional Feature:
- Macro RISCV_CORE_DIV_EARLY_OUT_EN.
- Defined: special cases (divisor 0, signed overflow) and the case |dividend| < |divisor| are detected at acceptance.
  - FSM goes IDLE -> DONE directly; o_div_valid in cycle 1.
  - For |dividend| < |divisor|: quotient 0, remainder = dividend.
- Undefined: all ops take the full N+1 latency. Special cases are still produced correctly, via override at DONE entry.

Decomposition:
- riscv_core_pkg holds:
  - div_op_e enum (DIV, DIVU, REM, REMU)
  - div_state_e enum (IDLE, CALC, DONE)
  - constant DIV_CNT_W = $clog2(XLEN)+1
- One sub-module: riscv_core_div_step. Combinational single iteration: inputs partial remainder, dividend MSB, divisor; outputs next remainder and quotient bit.

Test Plan:
- DIV rs1=-7 (0xFFFFFFFFFFFFFFF9), rs2=2 -> result 0xFFFFFFFFFFFFFFFD (-3) at cycle 65; o_div_ready back at cycle 66. REM on the same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFFFFFFFFFF; REMU on the same operands -> 0x1234. Valid at cycle 65, or cycle 1 with RISCV_CORE_DIV_EARLY_OUT_EN.
- DIV rs1=0x8000000000000000, rs2=-1 -> 0x8000000000000000; REM on the same operands -> 0.
- DIVW rs1=0x0000000180000000, rs2=0x00000000FFFFFFFF -> 0xFFFFFFFF80000000, valid at cycle 33. DIVUW rs1=0xFFFFFFFE, rs2=1 -> 0xFFFFFFFFFFFFFFFE.
- Start DIVU 100/7, assert i_div_flush at cycle 20 -> no o_div_valid, o_div_ready=1 at cycle 21. A new REMU 100/7 then yields 2.
- Start asserted during CALC -> ignored. Assert i_rst at cycle 10 -> all outputs at reset values next cycle.
